// File: rtl/perf_cnt_pkg.sv
// Shared definitions for the performance-counter bank: address map, CTRL bit
// positions, FSM state encoding and the request payload struct.
package perf_cnt_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 5;

  // Word address map
  localparam logic [ADDR_W-1:0] CNT_BASE  = 7'h00;
  localparam logic [ADDR_W-1:0] SEL_BASE  = 7'h40;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = 7'h60;
  localparam logic [ADDR_W-1:0] OVF_ADDR  = 7'h61;

  // Register bit positions
  localparam int unsigned CTRL_FREEZE_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT  = 1;
  localparam int unsigned SEL_EN_BIT      = 31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/perf_cnt_slice.sv
// One performance counter: SEL register (enable + event select), event mux,
// counter with write/clear override, wrap detect and optional sticky overflow.
// Optional feature macro: PERF_CNT_OVF_INTR_EN (sticky overflow flag).
// Ports:
//   clk, rst_n      clock, async active-low reset
//   evt_i           event pulse bus
//   freeze_i        global freeze, blocks increments
//   clear_i         zero the counter (wins over everything)
//   wr_lo_i/wr_hi_i write low/high 32-bit half from wdata_i
//   sel_wr_i        write SEL register from wdata_i
//   ovf_clr_i       clear sticky overflow
//   cnt_o, en_o, sel_o, ovf_o  current register state
module perf_cnt_slice
  import perf_cnt_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned NUM_EVT   = 32,
  parameter int unsigned EVT_SEL_W = 5,
  parameter int unsigned RST_SEL   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_EVT-1:0]   evt_i,
  input  logic                 freeze_i,
  input  logic                 clear_i,
  input  logic                 wr_lo_i,
  input  logic                 wr_hi_i,
  input  logic                 sel_wr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic                 ovf_clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 en_o,
  output logic [EVT_SEL_W-1:0] sel_o,
  output logic                 ovf_o
);

  localparam int unsigned EVT_PAD = 1 << EVT_SEL_W;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 en_q;
  logic [EVT_SEL_W-1:0] sel_q;
  logic [EVT_PAD-1:0]   evt_pad;
  logic [63:0]          wr64;
  logic                 inc_c;
  logic                 wrap_c;

  // Zero-padded bus: selects at or above NUM_EVT land on a constant 0
  assign evt_pad = EVT_PAD'(evt_i);
  assign inc_c   = en_q & evt_pad[sel_q] & ~freeze_i;

  // Counter next value: clear > half-word write > increment
  always_comb begin
    wr64 = 64'(cnt_q);
    if (wr_lo_i) wr64[31:0]  = wdata_i;
    if (wr_hi_i) wr64[63:32] = wdata_i;
    cnt_d  = cnt_q;
    wrap_c = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wr_lo_i || wr_hi_i) begin
      cnt_d = CNT_WIDTH'(wr64);
    end else if (inc_c) begin
      cnt_d  = cnt_q + CNT_WIDTH'(1);
      wrap_c = &cnt_q;
    end
  end

  // Counter and SEL registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      en_q  <= 1'b1;
      sel_q <= EVT_SEL_W'(RST_SEL);
    end else begin
      cnt_q <= cnt_d;
      if (sel_wr_i) begin
        en_q  <= wdata_i[SEL_EN_BIT];
        sel_q <= wdata_i[EVT_SEL_W-1:0];
      end
    end
  end

  assign cnt_o = cnt_q;
  assign en_o  = en_q;
  assign sel_o = sel_q;

`ifdef PERF_CNT_OVF_INTR_EN
  logic ovf_q, ovf_d;

  // Sticky overflow; a wrap on the same edge as a clear keeps it set
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (wrap_c)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_clr_i ^ wrap_c;
  assign ovf_o      = 1'b0;
`endif

endmodule

// File: rtl/perf_cnt_bank.sv
// Parametrised performance-counter bank: NUM_CNT event counters with a
// valid/ready register access channel, atomic 64-bit reads through a shared
// high-word shadow, global freeze / clear_all, and optional overflow interrupt.
// Optional feature macro: PERF_CNT_OVF_INTR_EN.
// Ports:
//   clk, rst            clock, async active-low reset
//   evt_i               one-cycle event pulses
//   req_valid/req_ready request handshake; req_write, req_addr, req_wdata
//   rsp_valid/rsp_ready response handshake; rsp_rdata (0 for writes)
//   cnt_lo_o            low 32 bits of every counter, counter 0 in the LSBs
//   ovf_intr            OR of sticky overflow flags (0 when feature disabled)
module perf_cnt_bank
  import perf_cnt_pkg::*;
#(
  parameter int unsigned NUM_CNT   = 16,
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned NUM_EVT   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVT-1:0]    evt_i,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [NUM_CNT*32-1:0] cnt_lo_o,
  output logic                  ovf_intr
);

  localparam int unsigned EVT_SEL_W = $clog2(NUM_EVT);

  req_t                 req;
  state_e               state_q, state_d;
  logic                 req_ready_q, rsp_valid_q;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [31:0]          shadow_q, shadow_d;
  logic                 freeze_q, freeze_d;

  logic                 accept_c, wr_acc_c, rd_acc_c;
  logic                 is_cnt_c, is_sel_c, is_ctrl_c, is_ovf_c, cnt_hi_c;
  logic [IDX_W-1:0]     cnt_idx_c, sel_idx_c;
  logic                 clear_all_c;
  logic [DATA_W-1:0]    rd_data_c;
  logic [63:0]          cnt_rd_c;
  logic [DATA_W-1:0]    sel_rd_c;

  logic [CNT_WIDTH-1:0] cnt    [NUM_CNT];
  logic [63:0]          cnt64  [NUM_CNT];
  logic [EVT_SEL_W-1:0] sel    [NUM_CNT];
  logic [NUM_CNT-1:0]   en_vec, ovf_vec;
  logic [NUM_CNT-1:0]   wr_lo_c, wr_hi_c, sel_wr_c, ovf_clr_c;

  assign req      = {req_write, req_addr, req_wdata};
  assign accept_c = req_valid & req_ready_q;
  assign wr_acc_c = accept_c & req.write;
  assign rd_acc_c = accept_c & ~req.write;

  // Address decode
  assign cnt_idx_c = req.addr[5:1];
  assign cnt_hi_c  = req.addr[0];
  assign sel_idx_c = req.addr[4:0];
  assign is_cnt_c  = ((req.addr & 7'h40) == CNT_BASE) && (32'(cnt_idx_c) < NUM_CNT);
  assign is_sel_c  = ((req.addr & 7'h60) == SEL_BASE) && (32'(sel_idx_c) < NUM_CNT);
  assign is_ctrl_c = (req.addr == CTRL_ADDR);
  assign is_ovf_c  = (req.addr == OVF_ADDR);

  assign clear_all_c = wr_acc_c & is_ctrl_c & req.wdata[CTRL_CLEAR_BIT];
  assign ovf_clr_c   = (wr_acc_c & is_ovf_c) ? req.wdata[NUM_CNT-1:0] : '0;

  // Per-counter write strobes and read-side muxes
  always_comb begin
    wr_lo_c  = '0;
    wr_hi_c  = '0;
    sel_wr_c = '0;
    cnt_rd_c = '0;
    sel_rd_c = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      wr_lo_c[i]  = wr_acc_c & is_cnt_c & ~cnt_hi_c & (cnt_idx_c == IDX_W'(i));
      wr_hi_c[i]  = wr_acc_c & is_cnt_c &  cnt_hi_c & (cnt_idx_c == IDX_W'(i));
      sel_wr_c[i] = wr_acc_c & is_sel_c & (sel_idx_c == IDX_W'(i));
      if (cnt_idx_c == IDX_W'(i)) cnt_rd_c = cnt64[i];
      if (sel_idx_c == IDX_W'(i)) sel_rd_c = {en_vec[i], 31'(sel[i])};
    end
  end

  // Read data; high counter words come from the shadow, not the live value
  always_comb begin
    rd_data_c = '0;
    if (is_cnt_c) begin
      rd_data_c = cnt_hi_c ? shadow_q : cnt_rd_c[31:0];
    end else if (is_sel_c) begin
      rd_data_c = sel_rd_c;
    end else if (is_ctrl_c) begin
      rd_data_c[CTRL_FREEZE_BIT] = freeze_q;
    end else if (is_ovf_c) begin
      rd_data_c = 32'(ovf_vec);
    end
  end

  // Next-state: handshake FSM, shadow latch, CTRL
  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    shadow_d = shadow_q;
    freeze_d = freeze_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_RESP;
          rdata_d = req.write ? '0 : rd_data_c;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear_all_c) begin
      shadow_d = '0;
    end else if (rd_acc_c && is_cnt_c && !cnt_hi_c) begin
      shadow_d = cnt_rd_c[63:32];
    end
    if (wr_acc_c && is_ctrl_c) freeze_d = req.wdata[CTRL_FREEZE_BIT];
  end

  // State register; handshake outputs registered alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      shadow_q    <= '0;
      freeze_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      rdata_q     <= rdata_d;
      shadow_q    <= shadow_d;
      freeze_q    <= freeze_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

  // Counter slices
  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_cnt_slice #(
      .CNT_WIDTH (CNT_WIDTH),
      .NUM_EVT   (NUM_EVT),
      .EVT_SEL_W (EVT_SEL_W),
      .RST_SEL   (g % NUM_EVT)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst),
      .evt_i     (evt_i),
      .freeze_i  (freeze_q),
      .clear_i   (clear_all_c),
      .wr_lo_i   (wr_lo_c[g]),
      .wr_hi_i   (wr_hi_c[g]),
      .sel_wr_i  (sel_wr_c[g]),
      .wdata_i   (req.wdata),
      .ovf_clr_i (ovf_clr_c[g]),
      .cnt_o     (cnt[g]),
      .en_o      (en_vec[g]),
      .sel_o     (sel[g]),
      .ovf_o     (ovf_vec[g])
    );
    assign cnt64[g]             = 64'(cnt[g]);
    assign cnt_lo_o[g*32 +: 32] = cnt64[g][31:0];
  end

`ifdef PERF_CNT_OVF_INTR_EN
  logic ovf_intr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_intr_q <= 1'b0;
    else      ovf_intr_q <= |ovf_vec;
  end

  assign ovf_intr = ovf_intr_q;
`else
  assign ovf_intr = 1'b0;
`endif

endmodule

// File: tb/tb_perf_cnt_bank.sv
// Directed bench for perf_cnt_bank (default parameters).
module tb_perf_cnt_bank;

  localparam int unsigned NUM_CNT = 16;
  localparam int unsigned NUM_EVT = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_EVT-1:0]    evt_i;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [6:0]            req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic [NUM_CNT*32-1:0] cnt_lo_o;
  logic                  ovf_intr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  perf_cnt_bank #(.NUM_CNT(NUM_CNT), .CNT_WIDTH(64), .NUM_EVT(NUM_EVT)) dut (
    .clk       (clk),
    .rst       (rst),
    .evt_i     (evt_i),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .cnt_lo_o  (cnt_lo_o),
    .ovf_intr  (ovf_intr)
  );

  // One request/response with rsp_ready high; called and returns at a negedge
  task automatic bus_txn(input logic wr, input logic [6:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (req_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL req_ready_wait addr=%h: req_ready=%b, required 1", addr, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
    n_cmp++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rsp_latency addr=%h: rsp_valid=%b req_ready=%b, required 1/0",
               addr, rsp_valid, req_ready);
    end
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    rd = rsp_rdata;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; evt_i = '0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rsp_rdata: got %h required 0", rsp_rdata); end
    n_cmp++; if (ovf_intr !== 1'b0) begin n_err++; $display("FAIL rst_ovf_intr: got %b required 0", ovf_intr); end
    n_cmp++; if (cnt_lo_o !== '0) begin n_err++; $display("FAIL rst_cnt_lo: got %h required 0", cnt_lo_o); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_count();
    logic [31:0] rd;
    evt_i[0] = 1'b1;
    repeat (100) @(negedge clk);
    evt_i = '0;
    n_cmp++; if (cnt_lo_o[31:0] !== 32'd100) begin n_err++; $display("FAIL cnt0_lo_out: got %0d required 100", cnt_lo_o[31:0]); end
    n_cmp++; if (cnt_lo_o[63:32] !== 32'd0) begin n_err++; $display("FAIL cnt1_lo_out: got %0d required 0", cnt_lo_o[63:32]); end
    bus_txn(1'b0, 7'h00, '0, rd);
    n_cmp++; if (rd !== 32'd100) begin n_err++; $display("FAIL rd_cnt0_lo: got %0d required 100", rd); end
    bus_txn(1'b0, 7'h01, '0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL rd_cnt0_hi: got %h required 0", rd); end
  endtask

  task automatic test_event_sel();
    logic [31:0] rd;
    bus_txn(1'b1, 7'h42, 32'h8000_0005, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL wr_rsp_data: got %h required 0", rd); end
    bus_txn(1'b0, 7'h42, '0, rd);
    n_cmp++; if (rd !== 32'h8000_0005) begin n_err++; $display("FAIL rd_sel2: got %h required 80000005", rd); end
    repeat (7) begin
      evt_i[5] = 1'b1; @(negedge clk);
      evt_i[5] = 1'b0; @(negedge clk);
    end
    bus_txn(1'b0, 7'h04, '0, rd);
    n_cmp++; if (rd !== 32'd7) begin n_err++; $display("FAIL rd_cnt2_sel5: got %0d required 7", rd); end
    bus_txn(1'b1, 7'h42, 32'h0000_001F, rd);
    bus_txn(1'b0, 7'h42, '0, rd);
    n_cmp++; if (rd !== 32'h0000_001F) begin n_err++; $display("FAIL rd_sel2_dis: got %h required 0000001f", rd); end
    repeat (3) begin
      evt_i[5] = 1'b1; evt_i[31] = 1'b1; @(negedge clk);
      evt_i = '0; @(negedge clk);
    end
    bus_txn(1'b0, 7'h04, '0, rd);
    n_cmp++; if (rd !== 32'd7) begin n_err++; $display("FAIL cnt2_disabled: got %0d required 7", rd); end
    n_cmp++; if (cnt_lo_o[5*32 +: 32] !== 32'd10) begin n_err++; $display("FAIL cnt5_lo_out: got %0d required 10", cnt_lo_o[5*32 +: 32]); end
  endtask

  task automatic test_atomic();
    logic [31:0] rd;
    bus_txn(1'b1, 7'h00, 32'hFFFF_FFFF, rd);
    bus_txn(1'b1, 7'h01, 32'h0000_0001, rd);
    evt_i[0] = 1'b1; @(negedge clk);
    evt_i = '0;
    n_cmp++; if (cnt_lo_o[31:0] !== 32'h0) begin n_err++; $display("FAIL carry_lo_out: got %h required 0", cnt_lo_o[31:0]); end
    bus_txn(1'b0, 7'h00, '0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL carry_rd_lo: got %h required 0", rd); end
    bus_txn(1'b1, 7'h01, 32'h0000_0055, rd);
    bus_txn(1'b0, 7'h01, '0, rd);
    n_cmp++; if (rd !== 32'h2) begin n_err++; $display("FAIL shadow_hi: got %h required 2", rd); end
    bus_txn(1'b0, 7'h00, '0, rd);
    bus_txn(1'b0, 7'h01, '0, rd);
    n_cmp++; if (rd !== 32'h55) begin n_err++; $display("FAIL shadow_relatch: got %h required 55", rd); end
    // write beats a same-cycle increment
    evt_i[0] = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h00; req_wdata = 32'h10;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; evt_i = '0;
    n_cmp++; if (cnt_lo_o[31:0] !== 32'h10) begin n_err++; $display("FAIL wr_over_inc: got %h required 10", cnt_lo_o[31:0]); end
    @(negedge clk);
    // high-word write: low half must not increment, no carry into high half
    bus_txn(1'b1, 7'h00, 32'hFFFF_FFFF, rd);
    evt_i[0] = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h01; req_wdata = 32'h7;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; evt_i = '0;
    n_cmp++; if (cnt_lo_o[31:0] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wr_hi_lo_hold: got %h required ffffffff", cnt_lo_o[31:0]); end
    @(negedge clk);
    bus_txn(1'b0, 7'h00, '0, rd);
    bus_txn(1'b0, 7'h01, '0, rd);
    n_cmp++; if (rd !== 32'h7) begin n_err++; $display("FAIL wr_hi_no_carry: got %h required 7", rd); end
  endtask

  task automatic test_freeze_clear();
    logic [31:0] rd;
    bus_txn(1'b1, 7'h60, 32'h1, rd);
    bus_txn(1'b0, 7'h60, '0, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL rd_ctrl_frz: got %h required 1", rd); end
    evt_i = '1;
    repeat (50) @(negedge clk);
    evt_i = '0;
    n_cmp++; if (cnt_lo_o[31:0] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL frz_cnt0: got %h required ffffffff", cnt_lo_o[31:0]); end
    n_cmp++; if (cnt_lo_o[63:32] !== 32'd0) begin n_err++; $display("FAIL frz_cnt1: got %0d required 0", cnt_lo_o[63:32]); end
    n_cmp++; if (cnt_lo_o[5*32 +: 32] !== 32'd10) begin n_err++; $display("FAIL frz_cnt5: got %0d required 10", cnt_lo_o[5*32 +: 32]); end
    bus_txn(1'b1, 7'h60, 32'h0, rd);
    evt_i[5] = 1'b1; @(negedge clk);
    evt_i = '0;
    n_cmp++; if (cnt_lo_o[5*32 +: 32] !== 32'd11) begin n_err++; $display("FAIL unfrz_cnt5: got %0d required 11", cnt_lo_o[5*32 +: 32]); end
    // clear_all with an event on the same edge
    evt_i[0] = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h60; req_wdata = 32'h2;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; evt_i = '0;
    n_cmp++; if (cnt_lo_o !== '0) begin n_err++; $display("FAIL clear_all: got %h required 0", cnt_lo_o); end
    @(negedge clk);
    bus_txn(1'b0, 7'h01, '0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL clear_shadow: got %h required 0", rd); end
    bus_txn(1'b0, 7'h60, '0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rd_ctrl_clr: got %h required 0", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h40;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8000_0000 || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d: rsp_valid=%b rdata=%h req_ready=%b, required 1/80000000/0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rsp_release: rsp_valid=%b req_ready=%b, required 0/1", rsp_valid, req_ready);
    end
    // reset while a response is pending
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h43;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid_resp: rsp_valid=%b req_ready=%b rdata=%h, required 0/1/0",
               rsp_valid, req_ready, rsp_rdata);
    end
    @(negedge clk);
    rst = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    bus_txn(1'b0, 7'h42, '0, rd);
    n_cmp++; if (rd !== 32'h8000_0002) begin n_err++; $display("FAIL sel2_after_rst: got %h required 80000002", rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    bus_txn(1'b1, 7'h20, 32'h1234, rd);
    bus_txn(1'b0, 7'h20, '0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rd_cnt16: got %h required 0", rd); end
    bus_txn(1'b0, 7'h50, '0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rd_sel16: got %h required 0", rd); end
    bus_txn(1'b0, 7'h7F, '0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rd_7f: got %h required 0", rd); end
    n_cmp++; if (cnt_lo_o !== '0) begin n_err++; $display("FAIL unmapped_wr: got %h required 0", cnt_lo_o); end
  endtask

  task automatic test_ovf();
    logic [31:0] rd;
    bus_txn(1'b1, 7'h06, 32'hFFFF_FFFF, rd);
    bus_txn(1'b1, 7'h07, 32'hFFFF_FFFF, rd);
    evt_i[3] = 1'b1; @(negedge clk);
    evt_i = '0;
    n_cmp++; if (cnt_lo_o[3*32 +: 32] !== 32'h0) begin n_err++; $display("FAIL wrap_cnt3: got %h required 0", cnt_lo_o[3*32 +: 32]); end
    @(negedge clk);
`ifdef PERF_CNT_OVF_INTR_EN
    n_cmp++; if (ovf_intr !== 1'b1) begin n_err++; $display("FAIL ovf_intr_set: got %b required 1", ovf_intr); end
    bus_txn(1'b0, 7'h61, '0, rd);
    n_cmp++; if (rd !== 32'h8) begin n_err++; $display("FAIL rd_ovf: got %h required 8", rd); end
    bus_txn(1'b1, 7'h61, 32'h8, rd);
    n_cmp++; if (ovf_intr !== 1'b0) begin n_err++; $display("FAIL ovf_intr_clr: got %b required 0", ovf_intr); end
    bus_txn(1'b0, 7'h61, '0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rd_ovf_clr: got %h required 0", rd); end
`else
    n_cmp++; if (ovf_intr !== 1'b0) begin n_err++; $display("FAIL ovf_intr_off: got %b required 0", ovf_intr); end
    bus_txn(1'b0, 7'h61, '0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rd_ovf_off: got %h required 0", rd); end
`endif
    bus_txn(1'b0, 7'h7F, '0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rd_7f_end: got %h required 0", rd); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_event_sel();
    test_atomic();
    test_freeze_clear();
    test_backpressure();
    test_unmapped();
    test_ovf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
